pacman_sprite_ctrl: RTL and testbench

PACMAN_SPRITE_CTRL -- requirements
Module: pacman_sprite_ctrl

---
 rtl/pacman_sprite_ctrl.sv | 150 +++++++++++++++
 tb/tb_pacman_sprite_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_sprite_ctrl.sv
// Pac-Man sprite controller.
// Selects the animated sprite frame from the heading and mouth phase.
// Arbitrates sprite ROM row fetches between the playfield renderer
// (requester 0) and the lives indicator (requester 1). Fetches are pipelined,
// so one grant can issue per cycle while the previous row is captured.
module pacman_sprite_ctrl #(
    parameter int unsigned ANIM_DIV = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [1:0]  dir,
    input  logic        moving,
    input  logic        req0,
    input  logic [4:0]  row0,
    input  logic        req1,
    input  logic [4:0]  row1,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        mouth_open
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_CLOSED = 1'b1
    } anim_state_t;

    localparam logic [3:0] CNT_WRAP     = 4'(ANIM_DIV - 1);
    localparam logic [2:0] FRAME_CLOSED = 3'd4;

    anim_state_t state_q, state_d;
    logic [3:0]  anim_cnt_q, anim_cnt_d;
    logic [1:0]  cur_dir_q, cur_dir_d;
    logic        last_gnt1_q, last_gnt1_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;

    logic        anim_wrap;
    logic [2:0]  anim_frame;
    logic        elig0, elig1;
    logic        pick0, pick1;

    assign anim_wrap = (anim_cnt_q == CNT_WRAP);

    // Mouth phase state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mouth phase: toggles only on a frame tick while moving at the end of a phase.
    always_comb begin
        state_d = state_q;
        if (frame_tick && moving && anim_wrap) begin
            state_d = (state_q == ST_OPEN) ? ST_CLOSED : ST_OPEN;
        end
    end

    // Phase-derived outputs: mouth flag and the frame used by requester 0.
    always_comb begin
        mouth_open = (state_q == ST_OPEN);
        anim_frame = (state_q == ST_OPEN) ? {1'b0, cur_dir_q} : FRAME_CLOSED;
    end

    // Heading latch and phase counter, both advanced only on a frame tick.
    always_comb begin
        cur_dir_d  = cur_dir_q;
        anim_cnt_d = anim_cnt_q;
        if (frame_tick) begin
            cur_dir_d = dir;
            if (!moving || anim_wrap) begin
                anim_cnt_d = 4'd0;
            end else begin
                anim_cnt_d = anim_cnt_q + 4'd1;
            end
        end
    end

    // Arbiter: a requester holding a grant this cycle sits out one edge; ties go
    // to whichever side was not served most recently.
    always_comb begin
        elig0       = req0 & ~gnt0_q;
        elig1       = req1 & ~gnt1_q;
        pick0       = elig0 & (~elig1 | last_gnt1_q);
        pick1       = elig1 & ~pick0;
        gnt0_d      = pick0;
        gnt1_d      = pick1;
        rom_addr_d  = rom_addr_q;
        last_gnt1_d = last_gnt1_q;
        if (pick0) begin
            rom_addr_d  = {anim_frame, row0};
            last_gnt1_d = 1'b0;
        end else if (pick1) begin
            rom_addr_d  = {3'b000, row1};
            last_gnt1_d = 1'b1;
        end
    end

    // Return stage: capture the ROM row one cycle after its grant.
    always_comb begin
        rvalid0_d = gnt0_q;
        rvalid1_d = gnt1_q;
        rdata_d   = (gnt0_q | gnt1_q) ? rom_data : rdata_q;
    end

    // Animation and fetch pipeline registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            anim_cnt_q  <= 4'd0;
            cur_dir_q   <= 2'b00;
            last_gnt1_q <= 1'b1;
            rom_addr_q  <= 8'd0;
            rdata_q     <= 32'd0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            anim_cnt_q  <= anim_cnt_d;
            cur_dir_q   <= cur_dir_d;
            last_gnt1_q <= last_gnt1_d;
            rom_addr_q  <= rom_addr_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rdata    = rdata_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;

endmodule

// File: tb/tb_pacman_sprite_ctrl.sv
// Scoreboard bench for pacman_sprite_ctrl: the driver predicts each edge from
// a behavioural model and queues expected grants, returns and mouth phase;
// a monitor compares the DUT outputs against those queues.
module tb_pacman_sprite_ctrl;

    localparam int ANIM_DIV = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic [1:0]  dir = 2'b00;
    logic        moving = 1'b0;
    logic        req0 = 1'b0;
    logic [4:0]  row0 = 5'd0;
    logic        req1 = 1'b0;
    logic [4:0]  row1 = 5'd0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        gnt0, gnt1;
    logic [31:0] rdata;
    logic        rvalid0, rvalid1;
    logic        mouth_open;

    pacman_sprite_ctrl #(.ANIM_DIV(ANIM_DIV)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .dir(dir),
        .moving(moving), .req0(req0), .row0(row0), .req1(req1), .row1(row1),
        .rom_addr(rom_addr), .rom_data(rom_data), .gnt0(gnt0), .gnt1(gnt1),
        .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1), .mouth_open(mouth_open)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom_fn(input logic [7:0] a);
        logic [7:0] m;
        m = 8'(a * 7 + 1);
        return {a, ~a, a ^ 8'h5A, m};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    typedef struct {
        int          cyc;
        logic [1:0]  who;
        logic [31:0] val;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    exp_t mq[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural model state
    int m_dir;
    bit m_open;
    int m_cnt;
    bit m_last1;
    bit m_gnt0, m_gnt1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_open = 1; m_cnt = 0; m_last1 = 1; m_gnt0 = 0; m_gnt1 = 0;
        gq.delete(); rq.delete(); mq.delete();
    endtask

    // Drive one cycle of inputs and predict the DUT's reaction at the next edge.
    task automatic step(input bit r0, input logic [4:0] w0, input bit r1, input logic [4:0] w1,
                        input bit tk, input logic [1:0] d, input bit mv);
        bit e0, e1, g0, g1;
        int a;
        logic [1:0] who;
        @(negedge Clk);
        req0 = r0; row0 = w0; req1 = r1; row1 = w1;
        frame_tick = tk; dir = d; moving = mv;
        e0 = r0 && !m_gnt0;
        e1 = r1 && !m_gnt1;
        g0 = e0 && (!e1 || m_last1);
        g1 = e1 && !g0;
        a = 0;
        if (g0) a = (m_open ? m_dir * 32 : 4 * 32) + int'(w0);
        if (g1) a = int'(w1);
        if (g0 || g1) begin
            who = g1 ? 2'b10 : 2'b01;
            gq.push_back('{cyc + 1, who, 32'(a)});
            rq.push_back('{cyc + 2, who, rom_fn(8'(a))});
            m_last1 = g1;
        end
        if (tk) begin
            m_dir = int'(d);
            if (!mv) m_cnt = 0;
            else if (m_cnt == ANIM_DIV - 1) begin
                m_cnt = 0;
                m_open = !m_open;
            end else m_cnt++;
        end
        mq.push_back('{cyc + 1, 2'b00, {31'b0, m_open}});
        m_gnt0 = g0;
        m_gnt1 = g1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    // Called just after a falling edge: assert reset mid-cycle, verify, release.
    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_mouth_open", {31'd0, mouth_open}, 32'd1);
        repeat (2) @(negedge Clk);
        req0 = 0; req1 = 0; frame_tick = 0; moving = 0; dir = 2'b00;
        #2;
        Reset_n = 1'b1;
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n) begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    e = gq.pop_front();
                    chk("gnt_missing_at_cyc", 32'(cyc), 32'(e.cyc));
                end
                if (gnt0 || gnt1) begin
                    if (gq.size() == 0) chk("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
                    else begin
                        e = gq.pop_front();
                        chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
                        chk("gnt_who", {30'd0, gnt1, gnt0}, {30'd0, e.who});
                        chk("gnt_rom_addr", {24'd0, rom_addr}, e.val);
                    end
                end
                while (rq.size() > 0 && rq[0].cyc < cyc) begin
                    e = rq.pop_front();
                    chk("rvalid_missing_at_cyc", 32'(cyc), 32'(e.cyc));
                end
                if (rvalid0 || rvalid1) begin
                    if (rq.size() == 0) chk("rvalid_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
                    else begin
                        e = rq.pop_front();
                        chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
                        chk("rvalid_who", {30'd0, rvalid1, rvalid0}, {30'd0, e.who});
                        chk("rvalid_rdata", rdata, e.val);
                    end
                end
                while (mq.size() > 0 && mq[0].cyc < cyc) void'(mq.pop_front());
                if (mq.size() > 0 && mq[0].cyc == cyc) begin
                    e = mq.pop_front();
                    chk("mouth_open", {31'd0, mouth_open}, e.val);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit r0, r1, mv, tk;
        logic [4:0] w0, w1;
        logic [1:0] d;
        model_reset();
        do_reset();

        // Single fetch from reset: row 5 of frame 0
        step(1, 5, 0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 0, 0, 2'b00, 0);
        idle(3);

        // Heading down, moving: mouth closes on the 4th tick, then closed-frame fetch
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 1, 2'b11, 1);
            step(0, 0, 0, 0, 0, 2'b11, 1);
        end
        step(1, 16, 0, 0, 0, 2'b11, 1);
        step(0, 0, 0, 0, 0, 2'b11, 1);
        idle(3);

        // Stop while CLOSED with count 2: phase held, count cleared, then 4 more ticks
        step(0, 0, 0, 0, 1, 2'b11, 1);
        step(0, 0, 0, 0, 1, 2'b11, 1);
        step(0, 0, 0, 0, 1, 2'b11, 0);
        idle(2);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 1, 2'b11, 1);
            step(0, 0, 0, 0, 0, 2'b11, 1);
        end
        idle(3);

        // Both requesters held high from reset: alternating grants
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 5'(i), 1, 5'(31 - i), 0, 2'b00, 0);
        idle(4);

        // Heading change between ticks has no effect until the next tick
        do_reset();
        step(0, 0, 0, 0, 0, 2'b10, 0);
        step(1, 0, 0, 0, 0, 2'b10, 0);
        step(0, 0, 0, 0, 0, 2'b10, 0);
        step(0, 0, 0, 0, 1, 2'b10, 0);
        step(1, 0, 0, 0, 0, 2'b10, 0);
        step(0, 0, 0, 0, 0, 2'b10, 0);
        idle(3);

        // Randomized traffic following the hold-until-grant protocol
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; mv = 0; d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (r0 && m_gnt0) begin
                r0 = ($urandom_range(0, 1) == 1);
                w0 = 5'($urandom_range(0, 31));
            end else if (r0 && $urandom_range(0, 19) == 0) r0 = 0;
            else if (!r0 && $urandom_range(0, 2) == 0) begin
                r0 = 1;
                w0 = 5'($urandom_range(0, 31));
            end
            if (r1 && m_gnt1) begin
                r1 = ($urandom_range(0, 1) == 1);
                w1 = 5'($urandom_range(0, 31));
            end else if (r1 && $urandom_range(0, 19) == 0) r1 = 0;
            else if (!r1 && $urandom_range(0, 2) == 0) begin
                r1 = 1;
                w1 = 5'($urandom_range(0, 31));
            end
            tk = ($urandom_range(0, 3) == 0);
            d  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mv = !mv;
            step(r0, w0, r1, w1, tk, d, mv);
        end
        idle(4);

        // Reset in the cycle after a grant: the in-flight fetch must vanish
        step(1, 9, 0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 0, 0, 2'b00, 0);
        do_reset();
        idle(6);

        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("return_queue_drained", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
